median_window_sequencer: RTL

//  Read-side controller for the 3x3 median filter. Walks the frame RAM holding a

---
 rtl/median_window_sequencer.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/median_window_sequencer.sv
// Read-side sequencer for the 3x3 median filter: walks every interior window of a
// WIDTHxHEIGHT frame, gathers its 9 pixels from the RAM and presents them over valid/ready.
module median_window_sequencer #(
    parameter int WIDTH  = 320,
    parameter int HEIGHT = 240,
    parameter int ADDR_W = 17,
    parameter int RD_LAT = 1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              ram_en_o,
    output logic [ADDR_W-1:0] ram_addr_o,
    input  logic [7:0]        ram_data_i,
    output logic              win_valid_o,
    input  logic              win_ready_i,
    output logic [71:0]       win_data_o,
    output logic [ADDR_W-1:0] win_addr_o,
    output logic              win_last_o
);

    localparam int COL_W = $clog2(WIDTH);
    localparam int ROW_W = $clog2(HEIGHT);
    localparam logic [COL_W-1:0]  COL_LAST = COL_W'(WIDTH - 3);
    localparam logic [ROW_W-1:0]  ROW_LAST = ROW_W'(HEIGHT - 3);
    localparam logic [ADDR_W-1:0] W1_A     = ADDR_W'(WIDTH);
    localparam logic [ADDR_W-1:0] W2_A     = ADDR_W'(2 * WIDTH);
    localparam logic [ADDR_W-1:0] CTR_OFF  = ADDR_W'(WIDTH + 1);
    localparam logic [3:0]        DRAIN_END = 4'(RD_LAT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DRAIN,
        S_PRESENT,
        S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [3:0]         cnt_q;
    logic [ADDR_W-1:0]  base_q;
    logic [COL_W-1:0]   col_q;
    logic [ROW_W-1:0]   row_q;
    logic               last_win;
    logic               drain_end;
    logic [RD_LAT-1:0]  rd_vld_p;
    logic [3:0]         rd_idx_p [RD_LAT];

    // Offset of tap k (row-major) from the window's top-left pixel.
    function automatic logic [ADDR_W-1:0] tap_offset(input logic [3:0] k);
        case (k)
            4'd1:    tap_offset = ADDR_W'(1);
            4'd2:    tap_offset = ADDR_W'(2);
            4'd3:    tap_offset = W1_A;
            4'd4:    tap_offset = W1_A + ADDR_W'(1);
            4'd5:    tap_offset = W1_A + ADDR_W'(2);
            4'd6:    tap_offset = W2_A;
            4'd7:    tap_offset = W2_A + ADDR_W'(1);
            4'd8:    tap_offset = W2_A + ADDR_W'(2);
            default: tap_offset = '0;
        endcase
    endfunction

    assign last_win  = (row_q == ROW_LAST) && (col_q == COL_LAST);
    assign drain_end = (cnt_q == DRAIN_END);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d     = state_q;
        busy_o      = 1'b0;
        done_o      = 1'b0;
        ram_en_o    = 1'b0;
        ram_addr_o  = '0;
        win_valid_o = 1'b0;
        win_last_o  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start_i) state_d = S_FETCH;
            end
            S_FETCH: begin
                busy_o     = 1'b1;
                ram_en_o   = 1'b1;
                ram_addr_o = base_q + tap_offset(cnt_q);
                if (cnt_q == 4'd8) state_d = S_DRAIN;
            end
            S_DRAIN: begin
                busy_o = 1'b1;
                if (drain_end) state_d = S_PRESENT;
            end
            S_PRESENT: begin
                busy_o      = 1'b1;
                win_valid_o = 1'b1;
                win_last_o  = last_win;
                if (win_ready_i) state_d = last_win ? S_DONE : S_FETCH;
            end
            S_DONE: begin
                done_o  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Window position: base tracks row*WIDTH+col so no multiplier is needed.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q      <= '0;
            base_q     <= '0;
            col_q      <= '0;
            row_q      <= '0;
            win_addr_o <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    cnt_q <= '0;
                    if (start_i) begin
                        base_q <= '0;
                        col_q  <= '0;
                        row_q  <= '0;
                    end
                end
                S_FETCH: cnt_q <= (cnt_q == 4'd8) ? 4'd0 : cnt_q + 4'd1;
                S_DRAIN: begin
                    if (drain_end) begin
                        cnt_q      <= '0;
                        win_addr_o <= base_q + CTR_OFF;
                    end else begin
                        cnt_q <= cnt_q + 4'd1;
                    end
                end
                S_PRESENT: begin
                    if (win_ready_i && !last_win) begin
                        if (col_q == COL_LAST) begin
                            col_q  <= '0;
                            row_q  <= row_q + ROW_W'(1);
                            base_q <= base_q + ADDR_W'(3);
                        end else begin
                            col_q  <= col_q + COL_W'(1);
                            base_q <= base_q + ADDR_W'(1);
                        end
                    end
                end
                default: cnt_q <= '0;
            endcase
        end
    end

    // Read pipe: p0 is one cycle after the address, last stage lines up with ram_data_i.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rd_vld_p <= '0;
        end else begin
            rd_vld_p[0] <= ram_en_o;
            for (int i = 1; i < RD_LAT; i++) rd_vld_p[i] <= rd_vld_p[i-1];
        end
    end

    always_ff @(posedge clk_i) begin
        rd_idx_p[0] <= cnt_q;
        for (int i = 1; i < RD_LAT; i++) rd_idx_p[i] <= rd_idx_p[i-1];
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            win_data_o <= '0;
        end else if (rd_vld_p[RD_LAT-1]) begin
            win_data_o[8*int'(rd_idx_p[RD_LAT-1]) +: 8] <= ram_data_i;
        end
    end

endmodule
